// File: rtl/ascon_permutation_engine_if.sv
// Request/result handshake between the mode controller, the Ascon permutation
// engine and the consumer of the permuted state.
interface ascon_permutation_engine_if;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 5;
  localparam int unsigned IDX_W     = 4;

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

  logic             start_i;
  logic [IDX_W-1:0] rounds_i;
  type_state        state_i;
  logic             ready_o;
  logic             valid_o;
  logic             out_ready_i;
  type_state        state_o;
  logic [IDX_W-1:0] round_o;

  modport master (
    output start_i, rounds_i, state_i, out_ready_i,
    input  ready_o, valid_o, state_o, round_o
  );

  modport slave (
    input  start_i, rounds_i, state_i, out_ready_i,
    output ready_o, valid_o, state_o, round_o
  );
endinterface

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation p^a: UNROLL rounds (constant add, S-box layer,
// linear diffusion) are evaluated per clock on a 320-bit state register.
module ascon_permutation_engine #(
  parameter int unsigned UNROLL = 1
) (
  input logic                       clock_i,
  input logic                       resetb_i,
  ascon_permutation_engine_if.slave bus
);
  localparam int unsigned WORD_W     = 64;
  localparam int unsigned NUM_WORDS  = 5;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned ROUNDS_MAX = 12;

  // Word index 0 is x0 (S-box MSB), index 4 is x4.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm_q;
  state_t           state_q;
  state_t           state_nxt_c;
  logic [IDX_W-1:0] round_q;
  logic [IDX_W-1:0] round_nxt_c;
  logic [IDX_W-1:0] round_start_c;
  logic [IDX_W:0]   round_sum_c;
  logic [IDX_W:0]   stage_idx_c;
  logic             ready_q;
  logic             valid_q;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x,
                                            input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Bitsliced form of the 5-bit S-box, applied to all 64 columns at once.
  function automatic state_t sbox_layer(input state_t s);
    logic [WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    state_t            r;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    r[0] = x0;
    r[1] = x1;
    r[2] = x2;
    r[3] = x3;
    r[4] = x4;
    return r;
  endfunction

  function automatic state_t diffusion(input state_t s);
    state_t r;
    r[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
    r[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
    r[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
    r[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
    r[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
    return r;
  endfunction

  function automatic state_t ascon_round(input state_t s, input logic [IDX_W-1:0] r);
    state_t t;
    t    = s;
    t[2] = t[2] ^ {56'h0, 4'(4'd15 - r), r};
    return diffusion(sbox_layer(t));
  endfunction

  // Unrolled round chain; stages past round 11 pass the state through.
  always_comb begin
    state_nxt_c = state_q;
    stage_idx_c = '0;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      stage_idx_c = (IDX_W+1)'(round_q) + (IDX_W+1)'(k);
      if (stage_idx_c < (IDX_W+1)'(ROUNDS_MAX)) begin
        state_nxt_c = ascon_round(state_nxt_c, stage_idx_c[IDX_W-1:0]);
      end
    end
  end

  // Round index advances by UNROLL and saturates at the final round count.
  assign round_sum_c = (IDX_W+1)'(round_q) + (IDX_W+1)'(UNROLL);
  assign round_nxt_c = (round_sum_c >= (IDX_W+1)'(ROUNDS_MAX)) ? IDX_W'(ROUNDS_MAX)
                                                               : round_sum_c[IDX_W-1:0];

  // Out-of-range round counts (0, 13..15) run the full twelve rounds.
  assign round_start_c = (bus.rounds_i == '0 || bus.rounds_i > IDX_W'(ROUNDS_MAX))
                         ? '0 : IDX_W'(ROUNDS_MAX) - bus.rounds_i;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= bus.state_i;
            round_q <= round_start_c;
            ready_q <= 1'b0;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          state_q <= state_nxt_c;
          round_q <= round_nxt_c;
          if (round_nxt_c == IDX_W'(ROUNDS_MAX)) begin
            valid_q <= 1'b1;
            fsm_q   <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            fsm_q   <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Directed bench for ascon_permutation_engine: one engine per legal UNROLL,
// all fed the same request stream, checked against a table-driven S-box model.
`timescale 1ns/1ps
module tb_ascon_permutation_engine;
  localparam int NDUT = 6;
  typedef logic [4:0][63:0] st_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  // Hand-derived ceil(a/U) for U = 1, 2, 3, 4, 6, 12.
  localparam int LAT12 [NDUT] = '{12, 6, 4, 3, 2, 1};
  localparam int LAT8  [NDUT] = '{8, 4, 3, 2, 2, 1};
  localparam int LAT6  [NDUT] = '{6, 3, 2, 2, 1, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic out_ready;
  logic [3:0] rounds;
  st_t  state_in;

  logic [NDUT-1:0] ready_v;
  logic [NDUT-1:0] valid_v;
  st_t             state_v [NDUT];
  logic [3:0]      round_v [NDUT];

  int  checks = 0;
  int  errors = 0;
  int  got_lat [NDUT];
  st_t got_st  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 :
                                (g == 3) ? 4 : (g == 4) ? 6 : 12;
    ascon_permutation_engine_if bus ();
    assign bus.start_i     = start;
    assign bus.rounds_i    = rounds;
    assign bus.state_i     = state_in;
    assign bus.out_ready_i = out_ready;
    assign ready_v[g]      = bus.ready_o;
    assign valid_v[g]      = bus.valid_o;
    assign state_v[g]      = bus.state_o;
    assign round_v[g]      = bus.round_o;
    ascon_permutation_engine #(.UNROLL(U)) dut (
      .clock_i  (clk),
      .resetb_i (rst_n),
      .bus      (bus)
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rot_r(input logic [63:0] x, input int n);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = x[6'((i + n) % 64)];
    return r;
  endfunction

  function automatic st_t add_const(input st_t s, input int r);
    st_t t = s;
    t[2] = t[2] ^ 64'((15 - r) * 16 + r);
    return t;
  endfunction

  function automatic st_t sbox_layer(input st_t s);
    st_t r;
    logic [4:0] col, o;
    for (int j = 0; j < 64; j++) begin
      col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      o   = SBOX[col];
      r[0][j] = o[4]; r[1][j] = o[3]; r[2][j] = o[2]; r[3][j] = o[1]; r[4][j] = o[0];
    end
    return r;
  endfunction

  function automatic st_t diffuse(input st_t s);
    st_t r;
    r[0] = s[0] ^ rot_r(s[0], 19) ^ rot_r(s[0], 28);
    r[1] = s[1] ^ rot_r(s[1], 61) ^ rot_r(s[1], 39);
    r[2] = s[2] ^ rot_r(s[2], 1)  ^ rot_r(s[2], 6);
    r[3] = s[3] ^ rot_r(s[3], 10) ^ rot_r(s[3], 17);
    r[4] = s[4] ^ rot_r(s[4], 7)  ^ rot_r(s[4], 41);
    return r;
  endfunction

  function automatic st_t model_perm(input st_t s, input logic [3:0] a);
    st_t t = s;
    int  n = (a == 4'd0 || a > 4'd12) ? 12 : int'(a);
    for (int r = 12 - n; r < 12; r++) t = diffuse(sbox_layer(add_const(t, r)));
    return t;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    start     = 1'b0;
    out_ready = 1'b1;
    while (ready_v != '1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ready_v !== '1) begin
      errors++;
      $display("FAIL wait_idle ready=%b required all ones", ready_v);
    end
  endtask

  // One request with out_ready high; records first-valid latency and result.
  task automatic run_req(input st_t s, input logic [3:0] a);
    wait_idle();
    state_in = s;
    rounds   = a;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    state_in = ~s;
    rounds   = 4'd3;
    for (int g = 0; g < NDUT; g++) got_lat[g] = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        if (valid_v[g] && got_lat[g] < 0) begin
          got_lat[g] = c;
          got_st[g]  = state_v[g];
        end
      end
    end
  endtask

  task automatic check_run(input string name, input st_t s, input logic [3:0] a,
                           input int lat [NDUT]);
    st_t exp = model_perm(s, a);
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if (got_lat[g] !== lat[g]) begin
        errors++;
        $display("FAIL %s latency dut%0d got %0d required %0d", name, g, got_lat[g], lat[g]);
      end
      checks++;
      if (got_st[g] !== exp) begin
        errors++;
        $display("FAIL %s state dut%0d got %h required %h", name, g, got_st[g], exp);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    start = 1'b0; out_ready = 1'b0; rounds = 4'd0; state_in = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    for (int g = 0; g < NDUT; g++) begin
      checks += 4;
      if (ready_v[g] !== 1'b1) begin errors++; $display("FAIL reset ready dut%0d got %b required 1", g, ready_v[g]); end
      if (valid_v[g] !== 1'b0) begin errors++; $display("FAIL reset valid dut%0d got %b required 0", g, valid_v[g]); end
      if (state_v[g] !== '0)   begin errors++; $display("FAIL reset state dut%0d got %h required 0", g, state_v[g]); end
      if (round_v[g] !== 4'd0) begin errors++; $display("FAIL reset round dut%0d got %0d required 0", g, round_v[g]); end
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_round();
    st_t z = '0;
    st_t p = sbox_layer(add_const(z, 11));
    st_t h;
    st_t pre_exp;
    pre_exp[0] = 64'h000000000000004B;
    pre_exp[1] = 64'h000000000000004B;
    pre_exp[2] = 64'hFFFFFFFFFFFFFFB4;
    pre_exp[3] = 64'h000000000000004B;
    pre_exp[4] = 64'h0;
    checks++;
    if (p !== pre_exp) begin errors++; $display("FAIL pre_diffusion got %h required %h", p, pre_exp); end
    h[0] = 64'h000964B00000004B;
    h[1] = 64'h0000000096000213;
    h[2] = 64'h53FFFFFFFFFFFF90;
    h[3] = 64'h12E580000000004B;
    h[4] = 64'h0;
    run_req(z, 4'd1);
    for (int g = 0; g < NDUT; g++) begin
      checks += 2;
      if (got_lat[g] !== 1) begin errors++; $display("FAIL one_round latency dut%0d got %0d required 1", g, got_lat[g]); end
      if (got_st[g] !== h)  begin errors++; $display("FAIL one_round state dut%0d got %h required %h", g, got_st[g], h); end
    end
  endtask

  task automatic test_unroll();
    st_t s;
    s = rand_state(); run_req(s, 4'd12); check_run("unroll_a12", s, 4'd12, LAT12);
    s = rand_state(); run_req(s, 4'd8);  check_run("unroll_a8",  s, 4'd8,  LAT8);
    s = rand_state(); run_req(s, 4'd6);  check_run("unroll_a6",  s, 4'd6,  LAT6);
  endtask

  task automatic test_rounds_saturate();
    st_t s = rand_state();
    run_req(s, 4'd0);  check_run("rounds0",  s, 4'd12, LAT12);
    run_req(s, 4'd15); check_run("rounds15", s, 4'd12, LAT12);
  endtask

  task automatic test_backpressure();
    st_t s = rand_state();
    st_t exp = model_perm(s, 4'd12);
    wait_idle();
    state_in = s; rounds = 4'd12; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      start = (c == 3 || c == 7);
      tick();
      checks++;
      if (ready_v !== '0) begin errors++; $display("FAIL bp_run ready cycle %0d got %b required 0", c, ready_v); end
    end
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      checks += 3;
      if (valid_v !== '1) begin errors++; $display("FAIL bp_done valid cycle %0d got %b required all ones", c, valid_v); end
      if (ready_v !== '0) begin errors++; $display("FAIL bp_done ready cycle %0d got %b required 0", c, ready_v); end
      if (state_v[0] !== exp || state_v[5] !== exp) begin
        errors++;
        $display("FAIL bp_done state cycle %0d got %h required %h", c, state_v[0], exp);
      end
    end
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    checks += 2;
    if (ready_v !== '1) begin errors++; $display("FAIL bp_retire ready got %b required all ones", ready_v); end
    if (valid_v !== '0) begin errors++; $display("FAIL bp_retire valid got %b required 0", valid_v); end
    tick(); tick();
    checks += 2;
    if (ready_v !== '1) begin errors++; $display("FAIL bp_no_accept ready got %b required all ones", ready_v); end
    if (round_v[0] !== 4'd12) begin errors++; $display("FAIL bp_no_accept round got %0d required 12", round_v[0]); end
  endtask

  task automatic test_async_reset();
    st_t s = rand_state();
    wait_idle();
    state_in = s; rounds = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks += 2;
    if (round_v[0] !== 4'd5) begin errors++; $display("FAIL mid_run round got %0d required 5", round_v[0]); end
    if (ready_v[0] !== 1'b0) begin errors++; $display("FAIL mid_run ready got %b required 0", ready_v[0]); end
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checks += 4;
      if (valid_v[g] !== 1'b0) begin errors++; $display("FAIL async_rst valid dut%0d got %b required 0", g, valid_v[g]); end
      if (state_v[g] !== '0)   begin errors++; $display("FAIL async_rst state dut%0d got %h required 0", g, state_v[g]); end
      if (round_v[g] !== 4'd0) begin errors++; $display("FAIL async_rst round dut%0d got %0d required 0", g, round_v[g]); end
      if (ready_v[g] !== 1'b1) begin errors++; $display("FAIL async_rst ready dut%0d got %b required 1", g, ready_v[g]); end
    end
    #10 rst_n = 1'b1;
    tick();
    s = rand_state();
    run_req(s, 4'd12);
    check_run("after_reset", s, 4'd12, LAT12);
  endtask

  task automatic test_back_to_back();
    st_t q [$];
    st_t drv;
    st_t exp;
    logic will_accept;
    int last = -1;
    int nres = 0;
    wait_idle();
    rounds = 4'd6; out_ready = 1'b1; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int w = 0; w < 5; w++) drv[w] = {8{8'(c * 5 + w + 1)}};
      state_in = drv;
      will_accept = ready_v[1];
      tick();
      if (will_accept) q.push_back(model_perm(drv, 4'd6));
      if (valid_v[1]) begin
        checks += 2;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b unexpected result cycle %0d", c);
        end else begin
          exp = q.pop_front();
          if (state_v[1] !== exp) begin
            errors++;
            $display("FAIL b2b state cycle %0d got %h required %h", c, state_v[1], exp);
          end
        end
        if ((last < 0 && c != 3) || (last >= 0 && c - last != 5)) begin
          errors++;
          $display("FAIL b2b spacing cycle %0d got %0d required 5 (first at 3)", c, c - last);
        end
        last = c;
        nres++;
      end
    end
    start = 1'b0;
    checks++;
    if (nres !== 8) begin errors++; $display("FAIL b2b count got %0d required 8", nres); end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_unroll();
    test_rounds_saturate();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
